// File: rtl/axi4lite_defs_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi4lite_defs
// Description : Shared AXI4-Lite response codes, port count and the state
//               encodings of the write/read channel FSMs in axi4lite_dist.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned NUM_PORTS = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2,
    W_ERR  = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2,
    R_ERR  = 2'd3
  } rd_state_t;

endpackage : axi4lite_defs
`default_nettype wire

// File: rtl/axi4lite_dist_dec.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_dist_dec
// Description : Combinational address decoder for the 1-to-4 AXI4-Lite
//               router. Extracts the 2-bit port-select field and flags
//               accesses to ports that are not present.
// Ports       : addr - 32-bit access address
//               sel  - selected port index
//               err  - 1 when the selected port is disabled (DECERR)
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_dist_dec #(
  parameter int unsigned ADDR_SEL_LO = 24,
  parameter logic [3:0]  PORT_EN     = 4'b1111
) (
  input  logic [31:0] addr,
  output logic [1:0]  sel,
  output logic        err
);

  assign sel = addr[ADDR_SEL_LO +: 2];
  assign err = ~PORT_EN[sel];

endmodule : axi4lite_dist_dec
`default_nettype wire

// File: rtl/axi4lite_dist.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_dist
// Description : 1-to-4 AXI4-Lite address router (SPI, UART, GPIO, timer).
//               One outstanding write and one outstanding read, handled by
//               two independent FSMs. Accesses to disabled ports are
//               answered internally with DECERR and never reach a peripheral.
// Ports       : clk_i / rst_i        - clock, asynchronous active-low reset
//               inport_*             - single upstream AXI4-Lite slave port
//               outport_*            - four downstream master ports; valids
//                                      and readies are one-hot, address and
//                                      data are broadcast from registers,
//                                      response buses are packed per port
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_dist
  import axi4lite_defs::*;
#(
  parameter int unsigned ADDR_SEL_LO = 24,
  parameter logic [3:0]  PORT_EN     = 4'b1111
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // upstream
  input  logic          inport_awvalid_i,
  output logic          inport_awready_o,
  input  logic [31:0]   inport_awaddr_i,
  input  logic          inport_wvalid_i,
  output logic          inport_wready_o,
  input  logic [31:0]   inport_wdata_i,
  input  logic [3:0]    inport_wstrb_i,
  output logic          inport_bvalid_o,
  input  logic          inport_bready_i,
  output logic [1:0]    inport_bresp_o,
  input  logic          inport_arvalid_i,
  output logic          inport_arready_o,
  input  logic [31:0]   inport_araddr_i,
  output logic          inport_rvalid_o,
  input  logic          inport_rready_i,
  output logic [31:0]   inport_rdata_o,
  output logic [1:0]    inport_rresp_o,
  // downstream
  output logic [3:0]    outport_awvalid_o,
  input  logic [3:0]    outport_awready_i,
  output logic [31:0]   outport_awaddr_o,
  output logic [3:0]    outport_wvalid_o,
  input  logic [3:0]    outport_wready_i,
  output logic [31:0]   outport_wdata_o,
  output logic [3:0]    outport_wstrb_o,
  input  logic [3:0]    outport_bvalid_i,
  output logic [3:0]    outport_bready_o,
  input  logic [7:0]    outport_bresp_i,
  output logic [3:0]    outport_arvalid_o,
  input  logic [3:0]    outport_arready_i,
  output logic [31:0]   outport_araddr_o,
  input  logic [3:0]    outport_rvalid_i,
  output logic [3:0]    outport_rready_o,
  input  logic [127:0]  outport_rdata_i,
  input  logic [7:0]    outport_rresp_i
);

  // --------------------------------------------------------------------------
  // Write channel state
  // --------------------------------------------------------------------------
  wr_state_t   wstate, wstate_nx;
  logic        aw_held_q, w_held_q;
  logic        aw_done_q, w_done_q;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  wsel_q;

  logic        aw_accept, w_accept;
  logic        out_aw_fire, out_w_fire;
  logic        wr_start, wr_finish;
  logic [31:0] wdec_addr;
  logic [1:0]  wdec_sel;
  logic        wdec_err;

  // --------------------------------------------------------------------------
  // Read channel state
  // --------------------------------------------------------------------------
  rd_state_t   rstate, rstate_nx;
  logic [31:0] araddr_q;
  logic [1:0]  rsel_q;
  logic        ar_accept;
  logic [1:0]  rdec_sel;
  logic        rdec_err;

  // The write address may arrive in the same cycle the FSM leaves IDLE, so
  // decode from the live bus until it has been captured.
  assign wdec_addr = aw_held_q ? awaddr_q : inport_awaddr_i;

  axi4lite_dist_dec #(
    .ADDR_SEL_LO (ADDR_SEL_LO),
    .PORT_EN     (PORT_EN)
  ) u_wdec (
    .addr (wdec_addr),
    .sel  (wdec_sel),
    .err  (wdec_err)
  );

  axi4lite_dist_dec #(
    .ADDR_SEL_LO (ADDR_SEL_LO),
    .PORT_EN     (PORT_EN)
  ) u_rdec (
    .addr (inport_araddr_i),
    .sel  (rdec_sel),
    .err  (rdec_err)
  );

  assign outport_awaddr_o = awaddr_q;
  assign outport_wdata_o  = wdata_q;
  assign outport_wstrb_o  = wstrb_q;
  assign outport_araddr_o = araddr_q;

  // --------------------------------------------------------------------------
  // Write FSM: state and holding registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wstate    <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wsel_q    <= '0;
    end else begin
      wstate <= wstate_nx;
      if (aw_accept) begin
        awaddr_q  <= inport_awaddr_i;
        aw_held_q <= 1'b1;
      end
      if (w_accept) begin
        wdata_q  <= inport_wdata_i;
        wstrb_q  <= inport_wstrb_i;
        w_held_q <= 1'b1;
      end
      if (wr_start) begin
        wsel_q <= wdec_sel;
      end
      if (out_aw_fire) begin
        aw_done_q <= 1'b1;
      end
      if (out_w_fire) begin
        w_done_q <= 1'b1;
      end
      if (wr_finish) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    wstate_nx         = wstate;
    inport_awready_o  = 1'b0;
    inport_wready_o   = 1'b0;
    inport_bvalid_o   = 1'b0;
    inport_bresp_o    = RESP_OKAY;
    outport_awvalid_o = '0;
    outport_wvalid_o  = '0;
    outport_bready_o  = '0;
    aw_accept         = 1'b0;
    w_accept          = 1'b0;
    out_aw_fire       = 1'b0;
    out_w_fire        = 1'b0;
    wr_start          = 1'b0;
    wr_finish         = 1'b0;

    unique case (wstate)
      W_IDLE: begin
        // Both readies stay high together while nothing is held.
        inport_awready_o = ~aw_held_q;
        inport_wready_o  = ~w_held_q;
        aw_accept        = inport_awvalid_i & ~aw_held_q;
        w_accept         = inport_wvalid_i & ~w_held_q;
        if ((aw_held_q | aw_accept) && (w_held_q | w_accept)) begin
          wr_start  = 1'b1;
          wstate_nx = wdec_err ? W_ERR : W_REQ;
        end
      end
      W_REQ: begin
        outport_awvalid_o[wsel_q] = ~aw_done_q;
        outport_wvalid_o[wsel_q]  = ~w_done_q;
        out_aw_fire = ~aw_done_q & outport_awready_i[wsel_q];
        out_w_fire  = ~w_done_q & outport_wready_i[wsel_q];
        if ((aw_done_q | out_aw_fire) && (w_done_q | out_w_fire)) begin
          wstate_nx = W_RESP;
        end
      end
      W_RESP: begin
        inport_bvalid_o          = outport_bvalid_i[wsel_q];
        inport_bresp_o           = outport_bresp_i[{wsel_q, 1'b0} +: 2];
        outport_bready_o[wsel_q] = inport_bready_i;
        if (outport_bvalid_i[wsel_q] && inport_bready_i) begin
          wr_finish = 1'b1;
          wstate_nx = W_IDLE;
        end
      end
      W_ERR: begin
        inport_bvalid_o = 1'b1;
        inport_bresp_o  = RESP_DECERR;
        if (inport_bready_i) begin
          wr_finish = 1'b1;
          wstate_nx = W_IDLE;
        end
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read FSM: state and holding registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rstate   <= R_IDLE;
      araddr_q <= '0;
      rsel_q   <= '0;
    end else begin
      rstate <= rstate_nx;
      if (ar_accept) begin
        araddr_q <= inport_araddr_i;
        rsel_q   <= rdec_sel;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    rstate_nx         = rstate;
    inport_arready_o  = 1'b0;
    inport_rvalid_o   = 1'b0;
    inport_rdata_o    = '0;
    inport_rresp_o    = RESP_OKAY;
    outport_arvalid_o = '0;
    outport_rready_o  = '0;
    ar_accept         = 1'b0;

    unique case (rstate)
      R_IDLE: begin
        inport_arready_o = 1'b1;
        ar_accept        = inport_arvalid_i;
        if (inport_arvalid_i) begin
          rstate_nx = rdec_err ? R_ERR : R_REQ;
        end
      end
      R_REQ: begin
        outport_arvalid_o[rsel_q] = 1'b1;
        if (outport_arready_i[rsel_q]) begin
          rstate_nx = R_RESP;
        end
      end
      R_RESP: begin
        inport_rvalid_o          = outport_rvalid_i[rsel_q];
        inport_rdata_o           = outport_rdata_i[{rsel_q, 5'b0} +: 32];
        inport_rresp_o           = outport_rresp_i[{rsel_q, 1'b0} +: 2];
        outport_rready_o[rsel_q] = inport_rready_i;
        if (outport_rvalid_i[rsel_q] && inport_rready_i) begin
          rstate_nx = R_IDLE;
        end
      end
      R_ERR: begin
        inport_rvalid_o = 1'b1;
        inport_rdata_o  = '0;
        inport_rresp_o  = RESP_DECERR;
        if (inport_rready_i) begin
          rstate_nx = R_IDLE;
        end
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

endmodule : axi4lite_dist
`default_nettype wire

// File: tb/tb_axi4lite_dist.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4lite_dist
// Description : Directed self-checking bench for axi4lite_dist. The test
//               addresses carry the port number in the top nibble, so the
//               routers are built with the select field at bit 28. A second
//               instance has port 3 removed to exercise internal DECERR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_dist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // ---- main instance (all ports present) ----
  logic         inport_awvalid_i = 0, inport_wvalid_i = 0, inport_bready_i = 0;
  logic         inport_arvalid_i = 0, inport_rready_i = 0;
  logic [31:0]  inport_awaddr_i = 0, inport_wdata_i = 0, inport_araddr_i = 0;
  logic [3:0]   inport_wstrb_i = 0;
  logic         inport_awready_o, inport_wready_o, inport_bvalid_o;
  logic         inport_arready_o, inport_rvalid_o;
  logic [1:0]   inport_bresp_o, inport_rresp_o;
  logic [31:0]  inport_rdata_o;
  logic [3:0]   outport_awready_i = 0, outport_wready_i = 0, outport_bvalid_i = 0;
  logic [3:0]   outport_arready_i = 0, outport_rvalid_i = 0;
  logic [7:0]   outport_bresp_i = 0, outport_rresp_i = 0;
  logic [127:0] outport_rdata_i = 0;
  logic [3:0]   outport_awvalid_o, outport_wvalid_o, outport_bready_o;
  logic [3:0]   outport_arvalid_o, outport_rready_o, outport_wstrb_o;
  logic [31:0]  outport_awaddr_o, outport_wdata_o, outport_araddr_o;

  axi4lite_dist #(.ADDR_SEL_LO(28), .PORT_EN(4'b1111)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .inport_awvalid_i(inport_awvalid_i), .inport_awready_o(inport_awready_o),
    .inport_awaddr_i(inport_awaddr_i),
    .inport_wvalid_i(inport_wvalid_i), .inport_wready_o(inport_wready_o),
    .inport_wdata_i(inport_wdata_i), .inport_wstrb_i(inport_wstrb_i),
    .inport_bvalid_o(inport_bvalid_o), .inport_bready_i(inport_bready_i),
    .inport_bresp_o(inport_bresp_o),
    .inport_arvalid_i(inport_arvalid_i), .inport_arready_o(inport_arready_o),
    .inport_araddr_i(inport_araddr_i),
    .inport_rvalid_o(inport_rvalid_o), .inport_rready_i(inport_rready_i),
    .inport_rdata_o(inport_rdata_o), .inport_rresp_o(inport_rresp_o),
    .outport_awvalid_o(outport_awvalid_o), .outport_awready_i(outport_awready_i),
    .outport_awaddr_o(outport_awaddr_o),
    .outport_wvalid_o(outport_wvalid_o), .outport_wready_i(outport_wready_i),
    .outport_wdata_o(outport_wdata_o), .outport_wstrb_o(outport_wstrb_o),
    .outport_bvalid_i(outport_bvalid_i), .outport_bready_o(outport_bready_o),
    .outport_bresp_i(outport_bresp_i),
    .outport_arvalid_o(outport_arvalid_o), .outport_arready_i(outport_arready_i),
    .outport_araddr_o(outport_araddr_o),
    .outport_rvalid_i(outport_rvalid_i), .outport_rready_o(outport_rready_o),
    .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i)
  );

  // ---- second instance (port 3 absent); peripherals never respond ----
  logic         e_awvalid = 0, e_wvalid = 0, e_bready = 0, e_arvalid = 0, e_rready = 0;
  logic [31:0]  e_awaddr = 0, e_araddr = 0;
  logic         e_awready, e_wready, e_bvalid, e_arready, e_rvalid;
  logic [1:0]   e_bresp, e_rresp;
  logic [31:0]  e_rdata, e_o_awaddr, e_o_wdata, e_o_araddr;
  logic [3:0]   e_o_awvalid, e_o_wvalid, e_o_bready, e_o_arvalid, e_o_rready, e_o_wstrb;
  logic [3:0]   e_zero4 = 0;
  logic [7:0]   e_zero8 = 0;
  logic [127:0] e_zero128 = 0;

  axi4lite_dist #(.ADDR_SEL_LO(28), .PORT_EN(4'b0111)) dut_en (
    .clk_i(clk), .rst_i(rst_n),
    .inport_awvalid_i(e_awvalid), .inport_awready_o(e_awready),
    .inport_awaddr_i(e_awaddr),
    .inport_wvalid_i(e_wvalid), .inport_wready_o(e_wready),
    .inport_wdata_i(32'h0000_0000), .inport_wstrb_i(4'hF),
    .inport_bvalid_o(e_bvalid), .inport_bready_i(e_bready),
    .inport_bresp_o(e_bresp),
    .inport_arvalid_i(e_arvalid), .inport_arready_o(e_arready),
    .inport_araddr_i(e_araddr),
    .inport_rvalid_o(e_rvalid), .inport_rready_i(e_rready),
    .inport_rdata_o(e_rdata), .inport_rresp_o(e_rresp),
    .outport_awvalid_o(e_o_awvalid), .outport_awready_i(e_zero4),
    .outport_awaddr_o(e_o_awaddr),
    .outport_wvalid_o(e_o_wvalid), .outport_wready_i(e_zero4),
    .outport_wdata_o(e_o_wdata), .outport_wstrb_o(e_o_wstrb),
    .outport_bvalid_i(e_zero4), .outport_bready_o(e_o_bready),
    .outport_bresp_i(e_zero8),
    .outport_arvalid_o(e_o_arvalid), .outport_arready_i(e_zero4),
    .outport_araddr_o(e_o_araddr),
    .outport_rvalid_i(e_zero4), .outport_rready_o(e_o_rready),
    .outport_rdata_i(e_zero128), .outport_rresp_i(e_zero8)
  );

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (inport_awready_o !== 1'b1) begin n_miss++; $display("FAIL reset_awready got %b want 1", inport_awready_o); end
    n_vec++; if (inport_wready_o !== 1'b1) begin n_miss++; $display("FAIL reset_wready got %b want 1", inport_wready_o); end
    n_vec++; if (inport_arready_o !== 1'b1) begin n_miss++; $display("FAIL reset_arready got %b want 1", inport_arready_o); end
    n_vec++; if ({inport_bvalid_o, inport_rvalid_o} !== 2'b00) begin n_miss++; $display("FAIL reset_bv_rv got %b want 00", {inport_bvalid_o, inport_rvalid_o}); end
    n_vec++; if ({outport_awvalid_o, outport_wvalid_o, outport_arvalid_o, outport_bready_o, outport_rready_o} !== 20'h0) begin
      n_miss++; $display("FAIL reset_outport_ctl got %h want 00000", {outport_awvalid_o, outport_wvalid_o, outport_arvalid_o, outport_bready_o, outport_rready_o});
    end
    n_vec++; if ({outport_awaddr_o, outport_wdata_o, outport_araddr_o} !== 96'h0) begin n_miss++; $display("FAIL reset_regs got %h want 0", {outport_awaddr_o, outport_wdata_o, outport_araddr_o}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // AW and W presented together to port 2, peripheral ready immediately.
  task automatic test_write_same_cycle(input string tag);
    @(negedge clk);
    inport_awvalid_i = 1; inport_awaddr_i = 32'h2000_0010;
    inport_wvalid_i = 1; inport_wdata_i = 32'hA5A5_0001; inport_wstrb_i = 4'hF;
    #1;
    n_vec++; if ({inport_awready_o, inport_wready_o} !== 2'b11) begin n_miss++; $display("FAIL %s_readies got %b want 11", tag, {inport_awready_o, inport_wready_o}); end
    @(negedge clk);
    inport_awvalid_i = 0; inport_wvalid_i = 0;
    #1;
    n_vec++; if (outport_awvalid_o !== 4'b0100) begin n_miss++; $display("FAIL %s_awvalid got %b want 0100", tag, outport_awvalid_o); end
    n_vec++; if (outport_wvalid_o !== 4'b0100) begin n_miss++; $display("FAIL %s_wvalid got %b want 0100", tag, outport_wvalid_o); end
    n_vec++; if ({outport_awaddr_o, outport_wdata_o, outport_wstrb_o} !== {32'h2000_0010, 32'hA5A5_0001, 4'hF}) begin
      n_miss++; $display("FAIL %s_payload got %h want %h", tag, {outport_awaddr_o, outport_wdata_o, outport_wstrb_o}, {32'h2000_0010, 32'hA5A5_0001, 4'hF});
    end
    n_vec++; if ({inport_awready_o, inport_wready_o} !== 2'b00) begin n_miss++; $display("FAIL %s_busy_readies got %b want 00", tag, {inport_awready_o, inport_wready_o}); end
    outport_awready_i = 4'b0100; outport_wready_i = 4'b0100;
    @(negedge clk);
    outport_awready_i = 0; outport_wready_i = 0;
    #1;
    n_vec++; if ({outport_awvalid_o, outport_wvalid_o, inport_bvalid_o} !== 9'h0) begin n_miss++; $display("FAIL %s_wait_b got %b want 0", tag, {outport_awvalid_o, outport_wvalid_o, inport_bvalid_o}); end
    // port 2 slice is 00; neighbouring slices are non-zero
    outport_bvalid_i = 4'b0100; outport_bresp_i = 8'b11_00_01_10; inport_bready_i = 1;
    #1;
    n_vec++; if ({inport_bvalid_o, inport_bresp_o} !== 3'b1_00) begin n_miss++; $display("FAIL %s_bresp got %b want 100", tag, {inport_bvalid_o, inport_bresp_o}); end
    n_vec++; if (outport_bready_o !== 4'b0100) begin n_miss++; $display("FAIL %s_bready got %b want 0100", tag, outport_bready_o); end
    @(negedge clk);
    outport_bvalid_i = 0; outport_bresp_i = 0; inport_bready_i = 0;
    #1;
    n_vec++; if ({inport_bvalid_o, inport_awready_o, inport_wready_o} !== 3'b011) begin n_miss++; $display("FAIL %s_done got %b want 011", tag, {inport_bvalid_o, inport_awready_o, inport_wready_o}); end
  endtask

  // W arrives 3 cycles ahead of AW; port 1 must see both together.
  task automatic test_w_before_aw();
    @(negedge clk);
    inport_wvalid_i = 1; inport_wdata_i = 32'h0000_BEEF; inport_wstrb_i = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      inport_wvalid_i = 0;
      #1;
      n_vec++; if ({inport_awready_o, inport_wready_o} !== 2'b10) begin n_miss++; $display("FAIL wfirst_readies_%0d got %b want 10", k, {inport_awready_o, inport_wready_o}); end
      n_vec++; if ({outport_awvalid_o, outport_wvalid_o} !== 8'h0) begin n_miss++; $display("FAIL wfirst_early_%0d got %b want 0", k, {outport_awvalid_o, outport_wvalid_o}); end
    end
    inport_awvalid_i = 1; inport_awaddr_i = 32'h1000_0000;
    @(negedge clk);
    inport_awvalid_i = 0;
    #1;
    n_vec++; if ({outport_awvalid_o, outport_wvalid_o} !== 8'b0010_0010) begin n_miss++; $display("FAIL wfirst_valids got %b want 00100010", {outport_awvalid_o, outport_wvalid_o}); end
    n_vec++; if ({outport_awaddr_o, outport_wdata_o, outport_wstrb_o} !== {32'h1000_0000, 32'h0000_BEEF, 4'b1100}) begin
      n_miss++; $display("FAIL wfirst_payload got %h want %h", {outport_awaddr_o, outport_wdata_o, outport_wstrb_o}, {32'h1000_0000, 32'h0000_BEEF, 4'b1100});
    end
    outport_awready_i = 4'b0010; outport_wready_i = 4'b0010;
    @(negedge clk);
    outport_awready_i = 0; outport_wready_i = 0;
    // spurious bvalid on port 0 must be ignored
    outport_bvalid_i = 4'b0011; outport_bresp_i = 8'b00_00_10_01; inport_bready_i = 1;
    #1;
    n_vec++; if ({inport_bvalid_o, inport_bresp_o} !== 3'b1_10) begin n_miss++; $display("FAIL wfirst_bresp got %b want 110", {inport_bvalid_o, inport_bresp_o}); end
    n_vec++; if (outport_bready_o !== 4'b0010) begin n_miss++; $display("FAIL wfirst_bready got %b want 0010", outport_bready_o); end
    @(negedge clk);
    outport_bvalid_i = 0; outport_bresp_i = 0; inport_bready_i = 0;
  endtask

  // Port 3 absent: read and write answered internally with DECERR.
  task automatic test_disabled_port();
    @(negedge clk);
    e_arvalid = 1; e_araddr = 32'h3000_0004;
    #1;
    n_vec++; if (e_arready !== 1'b1) begin n_miss++; $display("FAIL dis_arready got %b want 1", e_arready); end
    @(negedge clk);
    e_arvalid = 0;
    #1;
    n_vec++; if (e_o_arvalid !== 4'b0000) begin n_miss++; $display("FAIL dis_arvalid got %b want 0000", e_o_arvalid); end
    n_vec++; if ({e_rvalid, e_rdata, e_rresp} !== {1'b1, 32'h0, 2'b11}) begin n_miss++; $display("FAIL dis_rresp got %h want %h", {e_rvalid, e_rdata, e_rresp}, {1'b1, 32'h0, 2'b11}); end
    e_rready = 1;
    e_awvalid = 1; e_awaddr = 32'h3000_0000; e_wvalid = 1;
    @(negedge clk);
    e_rready = 0; e_awvalid = 0; e_wvalid = 0;
    #1;
    n_vec++; if ({e_rvalid, e_arready} !== 2'b01) begin n_miss++; $display("FAIL dis_rdone got %b want 01", {e_rvalid, e_arready}); end
    n_vec++; if ({e_o_awvalid, e_o_wvalid} !== 8'h0) begin n_miss++; $display("FAIL dis_awvalid got %b want 0", {e_o_awvalid, e_o_wvalid}); end
    n_vec++; if ({e_bvalid, e_bresp} !== 3'b1_11) begin n_miss++; $display("FAIL dis_bresp got %b want 111", {e_bvalid, e_bresp}); end
    e_bready = 1;
    @(negedge clk);
    e_bready = 0;
    #1;
    n_vec++; if ({e_bvalid, e_awready, e_wready} !== 3'b011) begin n_miss++; $display("FAIL dis_bdone got %b want 011", {e_bvalid, e_awready, e_wready}); end
  endtask

  // Port 0: W accepted at once, AW accepted on the 4th cycle.
  task automatic test_aw_delay();
    int bcount;
    @(negedge clk);
    inport_awvalid_i = 1; inport_awaddr_i = 32'h0000_0040;
    inport_wvalid_i = 1; inport_wdata_i = 32'h0BAD_F00D; inport_wstrb_i = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      inport_awvalid_i = 0; inport_wvalid_i = 0;
      #1;
      n_vec++; if (outport_awvalid_o !== 4'b0001) begin n_miss++; $display("FAIL awdly_awvalid_%0d got %b want 0001", k, outport_awvalid_o); end
      n_vec++; if (outport_wvalid_o !== ((k == 0) ? 4'b0001 : 4'b0000)) begin n_miss++; $display("FAIL awdly_wvalid_%0d got %b want %b", k, outport_wvalid_o, (k == 0) ? 4'b0001 : 4'b0000); end
      n_vec++; if (outport_awaddr_o !== 32'h0000_0040) begin n_miss++; $display("FAIL awdly_addr_%0d got %h want 00000040", k, outport_awaddr_o); end
      outport_wready_i  = (k == 0) ? 4'b0001 : 4'b0000;
      outport_awready_i = (k == 3) ? 4'b0001 : 4'b0000;
    end
    @(negedge clk);
    outport_awready_i = 0; outport_wready_i = 0;
    #1;
    n_vec++; if ({outport_awvalid_o, outport_wvalid_o} !== 8'h0) begin n_miss++; $display("FAIL awdly_drop got %b want 0", {outport_awvalid_o, outport_wvalid_o}); end
    outport_bvalid_i = 4'b0001; inport_bready_i = 1;
    bcount = 0;
    for (int j = 0; j < 4; j++) begin
      #1;
      if (inport_bvalid_o === 1'b1) bcount++;
      @(negedge clk);
      outport_bvalid_i = 0;
    end
    inport_bready_i = 0;
    n_vec++; if (bcount !== 1) begin n_miss++; $display("FAIL awdly_bcount got %0d want 1", bcount); end
  endtask

  // Read port 3 and write port 0 together; upstream R stalls 5 cycles.
  task automatic test_concurrent();
    @(negedge clk);
    outport_awready_i = 4'b1111; outport_wready_i = 4'b1111; outport_arready_i = 4'b1111;
    inport_arvalid_i = 1; inport_araddr_i = 32'h3000_0100;
    inport_awvalid_i = 1; inport_awaddr_i = 32'h0000_0008;
    inport_wvalid_i = 1; inport_wdata_i = 32'h1234_5678; inport_wstrb_i = 4'hF;
    @(negedge clk);
    inport_arvalid_i = 0; inport_awvalid_i = 0; inport_wvalid_i = 0;
    #1;
    n_vec++; if ({outport_arvalid_o, outport_awvalid_o, outport_wvalid_o} !== 12'b1000_0001_0001) begin
      n_miss++; $display("FAIL conc_valids got %b want 100000010001", {outport_arvalid_o, outport_awvalid_o, outport_wvalid_o});
    end
    n_vec++; if (outport_araddr_o !== 32'h3000_0100) begin n_miss++; $display("FAIL conc_araddr got %h want 30000100", outport_araddr_o); end
    @(negedge clk);
    outport_awready_i = 0; outport_wready_i = 0; outport_arready_i = 0;
    outport_rvalid_i = 4'b1000; outport_rresp_i = 8'b01_10_10_10;
    outport_rdata_i = {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    outport_bvalid_i = 4'b0001; outport_bresp_i = 8'b11_11_11_00; inport_bready_i = 1;
    #1;
    n_vec++; if ({inport_bvalid_o, inport_bresp_o, outport_bready_o} !== 7'b1_00_0001) begin n_miss++; $display("FAIL conc_b got %b want 1000001", {inport_bvalid_o, inport_bresp_o, outport_bready_o}); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      outport_bvalid_i = 0; inport_bready_i = 0;
      #1;
      n_vec++; if ({inport_rvalid_o, inport_rdata_o, inport_rresp_o} !== {1'b1, 32'hDEAD_BEEF, 2'b01}) begin
        n_miss++; $display("FAIL conc_rhold_%0d got %h want %h", k, {inport_rvalid_o, inport_rdata_o, inport_rresp_o}, {1'b1, 32'hDEAD_BEEF, 2'b01});
      end
      n_vec++; if (outport_rready_o !== 4'b0000) begin n_miss++; $display("FAIL conc_rready_lo_%0d got %b want 0000", k, outport_rready_o); end
    end
    n_vec++; if ({inport_awready_o, inport_wready_o, inport_bvalid_o} !== 3'b110) begin n_miss++; $display("FAIL conc_wdone got %b want 110", {inport_awready_o, inport_wready_o, inport_bvalid_o}); end
    inport_rready_i = 1;
    #1;
    n_vec++; if (outport_rready_o !== 4'b1000) begin n_miss++; $display("FAIL conc_rready got %b want 1000", outport_rready_o); end
    @(negedge clk);
    inport_rready_i = 0; outport_rvalid_i = 0;
    #1;
    n_vec++; if ({inport_rvalid_o, inport_arready_o} !== 2'b01) begin n_miss++; $display("FAIL conc_rdone got %b want 01", {inport_rvalid_o, inport_arready_o}); end
  endtask

  // Reset pulsed while a write waits for its response.
  task automatic test_reset_mid();
    @(negedge clk);
    inport_awvalid_i = 1; inport_awaddr_i = 32'h2000_0020;
    inport_wvalid_i = 1; inport_wdata_i = 32'h5555_AAAA; inport_wstrb_i = 4'hF;
    inport_arvalid_i = 1; inport_araddr_i = 32'h1000_0000;
    @(negedge clk);
    inport_awvalid_i = 0; inport_wvalid_i = 0; inport_arvalid_i = 0;
    outport_awready_i = 4'b0100; outport_wready_i = 4'b0100;
    @(negedge clk);
    outport_awready_i = 0; outport_wready_i = 0;
    outport_bvalid_i = 4'b0100;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; outport_bvalid_i = 0;
    @(negedge clk);
    #1;
    n_vec++; if ({outport_awvalid_o, outport_wvalid_o, outport_arvalid_o} !== 12'h0) begin n_miss++; $display("FAIL rstmid_valids got %b want 0", {outport_awvalid_o, outport_wvalid_o, outport_arvalid_o}); end
    n_vec++; if ({inport_awready_o, inport_wready_o, inport_arready_o, inport_bvalid_o, inport_rvalid_o} !== 5'b11100) begin
      n_miss++; $display("FAIL rstmid_up got %b want 11100", {inport_awready_o, inport_wready_o, inport_arready_o, inport_bvalid_o, inport_rvalid_o});
    end
    test_write_same_cycle("after_rst");
  endtask

  initial begin
    test_reset();
    test_write_same_cycle("wr_same");
    test_w_before_aw();
    test_disabled_port();
    test_aw_delay();
    test_concurrent();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_axi4lite_dist
`default_nettype wire
